// File: rtl/core_auto_pkg.sv
// Shared types and widths for the self-sequencing attention core (core_auto).
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KLOAD = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // mac_array instruction bits {inst[7], inst[6]}
  localparam logic [1:0] MAC_NOP  = 2'b00;
  localparam logic [1:0] MAC_LOAD = 2'b01;
  localparam logic [1:0] MAC_EXEC = 2'b10;

  function automatic int row_w(input int col, input int bw_psum);
    return col * bw_psum;
  endfunction

  function automatic int sum_w(input int col, input int bw_psum);
    return bw_psum + $clog2(col) + 1;
  endfunction

endpackage

// File: rtl/core_auto_if.sv
// Host-side bus of core_auto: Q/K writes, run control and psum readback.
// Handshake: start and rd_en are single-cycle requests honoured only while busy=0;
// done and out_valid are single-cycle responses with no back-pressure.
interface core_auto_if
  import core_pkg::*;
#(
  parameter int col     = 8,
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16
);
  localparam int aw = $clog2(depth);
  localparam int rw = row_w(col, bw_psum);
  localparam int sw = sum_w(col, bw_psum);

  logic [pr*bw-1:0] mem_in;
  logic             q_wr;
  logic             k_wr;
  logic [aw-1:0]    mem_add;
  logic [aw:0]      nq;
  logic             start;
  logic             rd_en;
  logic             busy;
  logic             done;
  logic [rw-1:0]    out;
  logic             out_valid;
  logic [sw-1:0]    sum_out;
  state_t           state;

  modport master (
    output mem_in, q_wr, k_wr, mem_add, nq, start, rd_en,
    input  busy, done, out, out_valid, sum_out, state
  );

  modport slave (
    input  mem_in, q_wr, k_wr, mem_add, nq, start, rd_en,
    output busy, done, out, out_valid, sum_out, state
  );
endinterface

// File: rtl/core_auto_prims.sv
// Datapath primitives of core_auto: single-port SRAM, weight-stationary MAC array, output FIFO.
module sram_w16 #(
  parameter int width = 64,
  parameter int depth = 16,
  parameter int aw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             cen,
  input  logic             wen,
  input  logic [aw-1:0]    a,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [width-1:0] mem [depth];

  // Active-low enables; q only updates on reads and has 1-cycle latency.
  always_ff @(posedge clk) begin
    if (!cen && !wen) mem[a] <= d;
    if (!cen && wen)  q <= mem[a];
  end
endmodule

module mac_array
  import core_pkg::*;
#(
  parameter int col     = 8,
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             inst,
  input  logic [pr*bw-1:0]       in,
  output logic [col*bw_psum-1:0] out,
  output logic                   valid
);
  logic [pr*bw-1:0]        w [col];
  logic [col*bw_psum-1:0]  dot;
  logic [bw_psum-1:0]      acc;
  logic signed [2*bw-1:0]  prod;

  always_comb begin
    dot  = '0;
    acc  = '0;
    prod = '0;
    for (int j = 0; j < col; j++) begin
      acc = '0;
      for (int i = 0; i < pr; i++) begin
        prod = $signed(in[i*bw +: bw]) * $signed(w[j][i*bw +: bw]);
        acc  = acc + {{(bw_psum-2*bw){prod[2*bw-1]}}, prod};
      end
      dot[j*bw_psum +: bw_psum] = acc;
    end
  end

  // Loads shift toward column 0 so that after col loads column j holds the j-th K row.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      out   <= '0;
      for (int j = 0; j < col; j++) w[j] <= '0;
    end else begin
      valid <= (inst == MAC_EXEC);
      if (inst == MAC_EXEC) out <= dot;
      if (inst == MAC_LOAD) begin
        for (int j = 0; j < col-1; j++) w[j] <= w[j+1];
        w[col-1] <= in;
      end
    end
  end
endmodule

module ofifo #(
  parameter int width = 160,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             valid
);
  localparam int pw = $clog2(depth) + 1;

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wp, rp;

  assign valid = (wp != rp);
  assign dout  = mem[rp[pw-2:0]];

  always_ff @(posedge clk) begin
    if (wr) mem[wp[pw-2:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr)          wp <= wp + pw'(1);
      if (rd && valid) rp <= rp + pw'(1);
    end
  end
endmodule

// File: rtl/core_auto_seq.sv
// Run sequencer of core_auto: IDLE -> KLOAD -> EXEC -> DRAIN, SRAM port muxing and drain control.
module core_seq
  import core_pkg::*;
#(
  parameter int col   = 8,
  parameter int depth = 16,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw:0]   nq,
  input  logic          q_wr,
  input  logic          k_wr,
  input  logic          rd_en,
  input  logic [aw-1:0] mem_add,
  input  logic          fifo_valid,
  output logic          busy,
  output logic          done,
  output state_t        state_dbg,
  output logic          q_cen,
  output logic          q_wen,
  output logic [aw-1:0] q_a,
  output logic          k_cen,
  output logic          k_wen,
  output logic [aw-1:0] k_a,
  output logic          p_cen,
  output logic          p_wen,
  output logic [aw-1:0] p_a,
  output logic [1:0]    mac_inst,
  output logic          fifo_rd,
  output logic          rd_issue
);
  localparam logic [aw:0] ONE      = (aw+1)'(1);
  localparam logic [aw:0] DEPTH_W  = (aw+1)'(depth);
  localparam logic [aw:0] COL_LAST = (aw+1)'(col-1);

  state_t      state, state_n;
  logic [aw:0] cnt, cnt_n, nq_r, nq_n, wr_ptr;
  logic [1:0]  inst_r, inst_n;
  logic        done_r, done_n;

  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign state_dbg = state;
  assign mac_inst  = inst_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      nq_r   <= '0;
      wr_ptr <= '0;
      inst_r <= MAC_NOP;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      nq_r   <= nq_n;
      inst_r <= inst_n;
      done_r <= done_n;
      if (state == IDLE && start) wr_ptr <= '0;
      else if (fifo_valid)        wr_ptr <= wr_ptr + ONE;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    nq_n     = nq_r;
    inst_n   = MAC_NOP;
    done_n   = 1'b0;
    q_cen    = 1'b1;
    q_wen    = 1'b1;
    q_a      = mem_add;
    k_cen    = 1'b1;
    k_wen    = 1'b1;
    k_a      = mem_add;
    rd_issue = 1'b0;
    // Any valid ofifo row is written back immediately, whatever the state.
    fifo_rd  = fifo_valid;
    p_cen    = !fifo_valid;
    p_wen    = !fifo_valid;
    p_a      = wr_ptr[aw-1:0];

    case (state)
      IDLE: begin
        if (q_wr) begin q_cen = 1'b0; q_wen = 1'b0; end
        if (k_wr) begin k_cen = 1'b0; k_wen = 1'b0; end
        if (rd_en && !fifo_valid) begin
          p_cen    = 1'b0;
          p_a      = mem_add;
          rd_issue = 1'b1;
        end
        if (start) begin
          if (nq == '0) begin
            done_n = 1'b1;
          end else begin
            nq_n    = (nq > DEPTH_W) ? DEPTH_W : nq;
            cnt_n   = '0;
            state_n = KLOAD;
          end
        end
      end
      KLOAD: begin
        k_cen  = 1'b0;
        k_a    = cnt[aw-1:0];
        inst_n = MAC_LOAD;
        if (cnt == COL_LAST) begin
          cnt_n   = '0;
          state_n = EXEC;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      EXEC: begin
        q_cen  = 1'b0;
        q_a    = cnt[aw-1:0];
        inst_n = MAC_EXEC;
        if (cnt == nq_r - ONE) state_n = DRAIN;
        else                   cnt_n   = cnt + ONE;
      end
      DRAIN: begin
        if (fifo_valid && wr_ptr == nq_r - ONE) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/core_auto.sv
// Self-sequencing attention core: Q/K SRAMs, MAC array, ofifo, psum SRAM and readback.
// Optional CORE_AUTO_RELU_EN clamps negative psum lanes to zero before they are stored.
module core_auto
  import core_pkg::*;
#(
  parameter int col     = 8,
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) (
  input  logic clk,
  input  logic reset,
  core_auto_if.slave bus
);
  localparam int RW = row_w(col, bw_psum);
  localparam int SW = sum_w(col, bw_psum);

  logic             q_cen, q_wen, k_cen, k_wen, p_cen, p_wen;
  logic [aw-1:0]    q_a, k_a, p_a;
  logic [pr*bw-1:0] q_data, k_data, mac_in;
  logic [1:0]       mac_inst;
  logic [RW-1:0]    mac_out, fifo_dout, p_d, p_q;
  logic             mac_valid, fifo_valid, fifo_rd, rd_issue;
  logic             busy, done, out_valid_r, read_seen;
  logic [SW-1:0]    row_sum;
  state_t           state;

  core_seq #(.col(col), .depth(depth), .aw(aw)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .nq        (bus.nq),
    .q_wr      (bus.q_wr),
    .k_wr      (bus.k_wr),
    .rd_en     (bus.rd_en),
    .mem_add   (bus.mem_add),
    .fifo_valid(fifo_valid),
    .busy      (busy),
    .done      (done),
    .state_dbg (state),
    .q_cen     (q_cen),
    .q_wen     (q_wen),
    .q_a       (q_a),
    .k_cen     (k_cen),
    .k_wen     (k_wen),
    .k_a       (k_a),
    .p_cen     (p_cen),
    .p_wen     (p_wen),
    .p_a       (p_a),
    .mac_inst  (mac_inst),
    .fifo_rd   (fifo_rd),
    .rd_issue  (rd_issue)
  );

  sram_w16 #(.width(pr*bw), .depth(depth), .aw(aw)) u_qmem (
    .clk(clk), .cen(q_cen), .wen(q_wen), .a(q_a), .d(bus.mem_in), .q(q_data)
  );

  sram_w16 #(.width(pr*bw), .depth(depth), .aw(aw)) u_kmem (
    .clk(clk), .cen(k_cen), .wen(k_wen), .a(k_a), .d(bus.mem_in), .q(k_data)
  );

  assign mac_in = (mac_inst == MAC_LOAD) ? k_data : q_data;

  mac_array #(.col(col), .pr(pr), .bw(bw), .bw_psum(bw_psum)) u_mac (
    .clk(clk), .reset(reset), .inst(mac_inst), .in(mac_in), .out(mac_out), .valid(mac_valid)
  );

  ofifo #(.width(RW), .depth(4)) u_ofifo (
    .clk(clk), .reset(reset), .wr(mac_valid), .din(mac_out),
    .rd(fifo_rd), .dout(fifo_dout), .valid(fifo_valid)
  );

  always_comb begin
    p_d = fifo_dout;
`ifdef CORE_AUTO_RELU_EN
    for (int j = 0; j < col; j++) begin
      if (fifo_dout[j*bw_psum + bw_psum-1]) p_d[j*bw_psum +: bw_psum] = '0;
    end
`endif
  end

  sram_w16 #(.width(RW), .depth(depth), .aw(aw)) u_pmem (
    .clk(clk), .cen(p_cen), .wen(p_wen), .a(p_a), .d(p_d), .q(p_q)
  );

  always_comb begin
    row_sum = '0;
    for (int j = 0; j < col; j++) begin
      row_sum = row_sum + {{(SW-bw_psum){p_q[j*bw_psum + bw_psum-1]}}, p_q[j*bw_psum +: bw_psum]};
    end
  end

  // out/sum_out follow the pmem read register; read_seen hides its pre-read contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      read_seen   <= 1'b0;
    end else begin
      out_valid_r <= rd_issue;
      if (rd_issue) read_seen <= 1'b1;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.state     = state;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = read_seen ? p_q : '0;
  assign bus.sum_out   = read_seen ? row_sum : '0;
endmodule
